// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: widths, ALU opcodes, forwarding
// select codes and the ID/EX slot record.
package mips_pkg;

   localparam int W  = 32;
   localparam int RA = 5;

   typedef enum logic [3:0] {
      ALU_NOP   = 4'b0000,
      ALU_ADD   = 4'b0001,
      ALU_SUB   = 4'b0010,
      ALU_NOT   = 4'b0011,
      ALU_AND   = 4'b0100,
      ALU_OR    = 4'b0101,
      ALU_SLL   = 4'b0110,
      ALU_SRL   = 4'b0111,
      ALU_LOADI = 4'b1000,
      ALU_SLT   = 4'b1001,
      ALU_BEQ   = 4'b1010,
      ALU_BNE   = 4'b1011
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic          valid;
      logic [3:0]    sel;
      logic [W-1:0]  rs_data;
      logic [W-1:0]  rt_data;
      logic [W-1:0]  imm;
      logic          use_imm;
      logic [RA-1:0] rs;
      logic [RA-1:0] rt;
      logic [RA-1:0] rd;
      logic          reg_write;
      logic          is_load;
   } issue_t;

   // An empty EX slot: ALU NOP, nothing written back, data cleared.
   function automatic issue_t bubble();
      issue_t b;
      b     = '0;
      b.sel = ALU_NOP;
      return b;
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side, forwarding-side and EX-side signals of the ID/EX issue stage.
interface alu_issue_if;
   import mips_pkg::*;

   logic          id_valid;
   logic [3:0]    id_sel;
   logic [W-1:0]  id_rs_data;
   logic [W-1:0]  id_rt_data;
   logic [W-1:0]  id_imm;
   logic          id_use_imm;
   logic [RA-1:0] id_rs;
   logic [RA-1:0] id_rt;
   logic [RA-1:0] id_rd;
   logic          id_reg_write;
   logic          id_is_load;
   logic          exmem_reg_write;
   logic [RA-1:0] exmem_rd;
   logic [W-1:0]  exmem_result;
   logic          memwb_reg_write;
   logic [RA-1:0] memwb_rd;
   logic [W-1:0]  memwb_result;
   logic          hold;
   logic          flush;
   logic          ex_valid;
   logic [3:0]    ex_sel;
   logic [W-1:0]  ex_a;
   logic [W-1:0]  ex_b;
   logic [RA-1:0] ex_rd;
   logic          ex_reg_write;
   logic          ex_is_load;
   logic          id_stall;
   fwd_sel_e      ex_fwd_a_sel;
   fwd_sel_e      ex_fwd_b_sel;

   modport master (
      output id_valid, id_sel, id_rs_data, id_rt_data, id_imm, id_use_imm,
             id_rs, id_rt, id_rd, id_reg_write, id_is_load,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result, hold, flush,
      input  ex_valid, ex_sel, ex_a, ex_b, ex_rd, ex_reg_write, ex_is_load,
             id_stall, ex_fwd_a_sel, ex_fwd_b_sel
   );

   modport slave (
      input  id_valid, id_sel, id_rs_data, id_rt_data, id_imm, id_use_imm,
             id_rs, id_rt, id_rd, id_reg_write, id_is_load,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result, hold, flush,
      output ex_valid, ex_sel, ex_a, ex_b, ex_rd, ex_reg_write, ex_is_load,
             id_stall, ex_fwd_a_sel, ex_fwd_b_sel
   );

endinterface

// File: rtl/alu_issue_fwd_mux.sv
// Operand bypass: picks EX/MEM, then MEM/WB, then register-file data for one
// source register; $0 is never bypassed.
module fwd_mux
   import mips_pkg::*;
(
   input  logic [RA-1:0] src_i,
   input  logic [W-1:0]  reg_data_i,
   input  logic          exmem_reg_write_i,
   input  logic [RA-1:0] exmem_rd_i,
   input  logic [W-1:0]  exmem_result_i,
   input  logic          memwb_reg_write_i,
   input  logic [RA-1:0] memwb_rd_i,
   input  logic [W-1:0]  memwb_result_i,
   output logic [W-1:0]  data_o,
   output fwd_sel_e      sel_o
);

   logic src_nz_s;

   assign src_nz_s = (src_i != {RA{1'b0}});

   always_comb begin
      sel_o  = FWD_REG;
      data_o = reg_data_i;
      if (src_nz_s && exmem_reg_write_i && (exmem_rd_i == src_i)) begin
         sel_o  = FWD_EXMEM;
         data_o = exmem_result_i;
      end else if (src_nz_s && memwb_reg_write_i && (memwb_rd_i == src_i)) begin
         sel_o  = FWD_MEMWB;
         data_o = memwb_result_i;
      end else begin
         sel_o  = FWD_REG;
         data_o = reg_data_i;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: registers the decoded slot, bypasses operands into the
// ALU, and inserts bubbles for load-use hazards and taken-branch flushes.
module alu_issue
   import mips_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   alu_issue_if.slave bus
);

   issue_t        slot_q;
   issue_t        slot_d;
   logic          stall_s;
   logic          hazard_s;
   logic [W-1:0]  fwd_rs_s;
   logic [W-1:0]  fwd_rt_s;
   logic [W-1:0]  b_s;
   fwd_sel_e      fwd_a_sel_s;
   fwd_sel_e      fwd_b_sel_s;

   // A load in EX whose destination a decode source needs; $0 never matches.
   assign hazard_s = slot_q.valid && slot_q.is_load &&
                     (slot_q.rd != {RA{1'b0}}) && bus.id_valid &&
                     ((bus.id_rs == slot_q.rd) ||
                      (!bus.id_use_imm && (bus.id_rt == slot_q.rd)));

   always_comb begin
      stall_s = 1'b0;
      if (hazard_s && !bus.flush) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end
   end

   always_comb begin
      slot_d = slot_q;
      if (bus.hold) begin
         slot_d = slot_q;
      end else if (bus.flush || stall_s || !bus.id_valid) begin
         slot_d = bubble();
      end else begin
         slot_d.valid     = 1'b1;
         slot_d.sel       = bus.id_sel;
         slot_d.rs_data   = bus.id_rs_data;
         slot_d.rt_data   = bus.id_rt_data;
         slot_d.imm       = bus.id_imm;
         slot_d.use_imm   = bus.id_use_imm;
         slot_d.rs        = bus.id_rs;
         slot_d.rt        = bus.id_rt;
         slot_d.rd        = bus.id_rd;
         slot_d.reg_write = bus.id_reg_write;
         slot_d.is_load   = bus.id_is_load;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= bubble();
      end else begin
         slot_q <= slot_d;
      end
   end

   fwd_mux u_fwd_rs (
      .src_i             (slot_q.rs),
      .reg_data_i        (slot_q.rs_data),
      .exmem_reg_write_i (bus.exmem_reg_write),
      .exmem_rd_i        (bus.exmem_rd),
      .exmem_result_i    (bus.exmem_result),
      .memwb_reg_write_i (bus.memwb_reg_write),
      .memwb_rd_i        (bus.memwb_rd),
      .memwb_result_i    (bus.memwb_result),
      .data_o            (fwd_rs_s),
      .sel_o             (fwd_a_sel_s)
   );

   fwd_mux u_fwd_rt (
      .src_i             (slot_q.rt),
      .reg_data_i        (slot_q.rt_data),
      .exmem_reg_write_i (bus.exmem_reg_write),
      .exmem_rd_i        (bus.exmem_rd),
      .exmem_result_i    (bus.exmem_result),
      .memwb_reg_write_i (bus.memwb_reg_write),
      .memwb_rd_i        (bus.memwb_rd),
      .memwb_result_i    (bus.memwb_result),
      .data_o            (fwd_rt_s),
      .sel_o             (fwd_b_sel_s)
   );

   always_comb begin
      b_s = fwd_rt_s;
      if (slot_q.use_imm) begin
         b_s = slot_q.imm;
      end else begin
         b_s = fwd_rt_s;
      end
   end

   assign bus.ex_valid     = slot_q.valid;
   assign bus.ex_sel       = slot_q.sel;
   assign bus.ex_rd        = slot_q.rd;
   assign bus.ex_reg_write = slot_q.reg_write;
   assign bus.ex_is_load   = slot_q.is_load;
   assign bus.ex_a         = fwd_rs_s;
   assign bus.ex_b         = b_s;
   assign bus.id_stall     = stall_s;
   assign bus.ex_fwd_a_sel = fwd_a_sel_s;
   assign bus.ex_fwd_b_sel = fwd_b_sel_s;

endmodule

// File: tb/tb_alu_issue.sv
// Directed and randomized checks of alu_issue against a slot-level reference model.
module tb_alu_issue;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_mis;

   alu_issue_if bus ();

   alu_issue dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [3:0]  sel;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic        use_imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        reg_write;
      logic        is_load;
   } slot_t;

   slot_t m;

   function automatic slot_t empty_slot();
      slot_t s;
      s.valid = 1'b0; s.sel = 4'd0; s.rs_data = 32'd0; s.rt_data = 32'd0;
      s.imm = 32'd0; s.use_imm = 1'b0; s.rs = 5'd0; s.rt = 5'd0; s.rd = 5'd0;
      s.reg_write = 1'b0; s.is_load = 1'b0;
      return s;
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
      if (r == 5'd0) return d;
      if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
      if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
      return d;
   endfunction

   function automatic logic exp_stall();
      if (bus.flush || !m.valid || !m.is_load || m.rd == 5'd0 || !bus.id_valid) return 1'b0;
      return (bus.id_rs == m.rd) || (!bus.id_use_imm && bus.id_rt == m.rd);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ex_valid",     {31'd0, bus.ex_valid},     {31'd0, m.valid});
      chk("ex_sel",       {28'd0, bus.ex_sel},       {28'd0, m.sel});
      chk("ex_rd",        {27'd0, bus.ex_rd},        {27'd0, m.rd});
      chk("ex_reg_write", {31'd0, bus.ex_reg_write}, {31'd0, m.reg_write});
      chk("ex_is_load",   {31'd0, bus.ex_is_load},   {31'd0, m.is_load});
      chk("ex_a", bus.ex_a, fwd(m.rs, m.rs_data));
      chk("ex_b", bus.ex_b, m.use_imm ? m.imm : fwd(m.rt, m.rt_data));
      chk("id_stall", {31'd0, bus.id_stall}, {31'd0, exp_stall()});
   endtask

   // Advance the model by the slot-update rules, then cross the clock edge.
   task automatic tick();
      if (!bus.hold) begin
         if (bus.flush || exp_stall() || !bus.id_valid) begin
            m = empty_slot();
         end else begin
            m.valid = 1'b1; m.sel = bus.id_sel; m.rs_data = bus.id_rs_data;
            m.rt_data = bus.id_rt_data; m.imm = bus.id_imm; m.use_imm = bus.id_use_imm;
            m.rs = bus.id_rs; m.rt = bus.id_rt; m.rd = bus.id_rd;
            m.reg_write = bus.id_reg_write; m.is_load = bus.id_is_load;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid = 1'b0; bus.id_sel = 4'd0; bus.id_rs_data = 32'd0; bus.id_rt_data = 32'd0;
      bus.id_imm = 32'd0; bus.id_use_imm = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
      bus.id_rd = 5'd0; bus.id_reg_write = 1'b0; bus.id_is_load = 1'b0;
      bus.exmem_reg_write = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd0;
      bus.memwb_reg_write = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd0;
      bus.hold = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic issue(input logic [3:0] sel, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                        input logic ld);
      bus.id_valid = 1'b1; bus.id_sel = sel; bus.id_rs = rs; bus.id_rs_data = rsd;
      bus.id_rt = rt; bus.id_rt_data = rtd; bus.id_rd = rd; bus.id_reg_write = 1'b1;
      bus.id_is_load = ld; bus.id_use_imm = 1'b0; bus.id_imm = 32'd0;
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      rst_n = 1'b0;
      idle();
      m = empty_slot();
      #1;
      check_all();
      chk("reset_ex_a", bus.ex_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Pass-through ADD r3(5), r4(7)
      issue(4'b0001, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 1'b0);
      tick();
      chk("pt_sel", {28'd0, bus.ex_sel}, 32'd1);
      chk("pt_a", bus.ex_a, 32'd5);
      chk("pt_b", bus.ex_b, 32'd7);
      chk("pt_valid", {31'd0, bus.ex_valid}, 32'd1);

      // Forwarding priority on rs=3
      bus.id_valid = 1'b0;
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'd11;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'd22;
      #1;
      chk("fwd_exmem", bus.ex_a, 32'd11);
      bus.exmem_reg_write = 1'b0;
      #1;
      chk("fwd_memwb", bus.ex_a, 32'd22);
      check_all();

      // $0 is never bypassed
      idle();
      issue(4'b0001, 5'd0, 32'd0, 5'd4, 32'd7, 5'd9, 1'b0);
      tick();
      bus.id_valid = 1'b0;
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd99;
      #1;
      chk("r0_a", bus.ex_a, 32'd0);

      // Load-use: load r8, then ADD rs=8
      idle();
      issue(4'b0001, 5'd1, 32'd100, 5'd0, 32'd0, 5'd8, 1'b1);
      tick();
      issue(4'b0001, 5'd8, 32'd0, 5'd2, 32'd3, 5'd10, 1'b0);
      #1;
      chk("lu_stall", {31'd0, bus.id_stall}, 32'd1);
      tick();
      chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("lu_bubble_sel", {28'd0, bus.ex_sel}, 32'd0);
      chk("lu_stall_clear", {31'd0, bus.id_stall}, 32'd0);
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd8; bus.exmem_result = 32'h55;
      tick();
      bus.exmem_reg_write = 1'b0; bus.exmem_rd = 5'd0;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'h1234;
      bus.id_valid = 1'b0;
      #1;
      chk("lu_dep_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("lu_dep_a", bus.ex_a, 32'h1234);
      check_all();

      // Flush squashes SUB
      idle();
      issue(4'b0010, 5'd1, 32'd9, 5'd2, 32'd4, 5'd5, 1'b0);
      bus.flush = 1'b1;
      tick();
      chk("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("fl_rw", {31'd0, bus.ex_reg_write}, 32'd0);

      // Flush with a simultaneous load-use
      idle();
      issue(4'b0001, 5'd1, 32'd1, 5'd0, 32'd0, 5'd8, 1'b1);
      tick();
      issue(4'b0001, 5'd8, 32'd0, 5'd2, 32'd3, 5'd10, 1'b0);
      bus.flush = 1'b1;
      #1;
      chk("fl_lu_stall", {31'd0, bus.id_stall}, 32'd0);
      tick();
      chk("fl_lu_valid", {31'd0, bus.ex_valid}, 32'd0);

      // Hold with flush for 3 cycles
      idle();
      issue(4'b0001, 5'd5, 32'h77, 5'd6, 32'h88, 5'd7, 1'b0);
      tick();
      issue(4'b0010, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 1'b0);
      bus.hold = 1'b1; bus.flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", {31'd0, bus.ex_valid}, 32'd1);
         chk("hold_sel", {28'd0, bus.ex_sel}, 32'd1);
         chk("hold_a", bus.ex_a, 32'h77);
         chk("hold_b", bus.ex_b, 32'h88);
      end
      bus.hold = 1'b0;
      tick();
      chk("unhold_valid", {31'd0, bus.ex_valid}, 32'd0);

      // Async reset mid-cycle, during a load-use stall
      idle();
      issue(4'b0001, 5'd1, 32'd1, 5'd0, 32'd0, 5'd8, 1'b1);
      tick();
      issue(4'b0001, 5'd8, 32'd6, 5'd2, 32'd3, 5'd10, 1'b0);
      #2;
      chk("pre_rst_stall", {31'd0, bus.id_stall}, 32'd1);
      rst_n = 1'b0;
      m = empty_slot();
      #1;
      chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("rst_stall", {31'd0, bus.id_stall}, 32'd0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("post_rst_a", bus.ex_a, 32'd6);
      check_all();

      // Randomized traffic with small register numbers to provoke matches
      for (int i = 0; i < 400; i++) begin
         bus.id_valid = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
         bus.id_sel = 4'($urandom_range(0, 11));
         bus.id_rs_data = $urandom(); bus.id_rt_data = $urandom(); bus.id_imm = $urandom();
         bus.id_use_imm = 1'($urandom_range(0, 1));
         bus.id_rs = 5'($urandom_range(0, 7)); bus.id_rt = 5'($urandom_range(0, 7));
         bus.id_rd = 5'($urandom_range(0, 7));
         bus.id_reg_write = 1'($urandom_range(0, 1));
         bus.id_is_load = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
         bus.exmem_reg_write = 1'($urandom_range(0, 1));
         bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_result = $urandom();
         bus.memwb_reg_write = 1'($urandom_range(0, 1));
         bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_result = $urandom();
         bus.hold = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
         bus.flush = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
         #1;
         check_all();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
